// File: rtl/nios2_subsystem_pio_pkg.sv
// Shared register offsets and bit positions for the Nios II FIFO-backed output PIO.
package nios2_subsystem_pio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_IRQ_PEND  = 3;
  localparam int STAT_LEVEL_LSB = 8;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/nios2_subsystem_pio_fifo_core.sv
// Synchronous show-ahead FIFO with level counter; flush overrides any same-cycle push/pop.
module nios2_subsystem_pio_fifo_core #(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [LVL_W-1:0]      level,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty     = (level == '0);
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign pop_ok    = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push & (~full | pop_ok);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nios2_subsystem_pio_fifo_out.sv
// Avalon-MM output PIO: CPU writes are queued and drained over a valid/ready stream.
module nios2_subsystem_pio_fifo_out
  import nios2_subsystem_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  wr;
  logic                  data_wr;
  logic                  status_wr;
  logic                  ctrl_wr;
  logic                  thresh_wr;
  logic                  pop;
  logic                  flush;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  irq_pending;
  logic [DATA_WIDTH-1:0] last_wr;
  logic                  enable;
  logic                  irq_en;
  logic                  overflow;
  logic [LVL_W-1:0]      threshold;

  assign wr        = chipselect & ~write_n;
  assign data_wr   = wr & (address == ADDR_DATA);
  assign status_wr = wr & (address == ADDR_STATUS);
  assign ctrl_wr   = wr & (address == ADDR_CTRL);
  assign thresh_wr = wr & (address == ADDR_THRESH);
  assign flush     = ctrl_wr & writedata[CTRL_FLUSH];

  assign out_valid   = enable & ~empty;
  assign out_data    = head_data;
  assign pop         = out_valid & out_ready;
  assign irq_pending = (level <= threshold);

  nios2_subsystem_pio_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_wr),
    .pop       (pop),
    .flush     (flush),
    .push_data (writedata[DATA_WIDTH-1:0]),
    .head_data (head_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Overflow marks a dropped push; only a STATUS write clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr   <= '0;
      enable    <= 1'b1;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      threshold <= '0;
      irq       <= 1'b0;
    end else begin
      irq <= irq_en & irq_pending;
      if (data_wr) begin
        last_wr <= writedata[DATA_WIDTH-1:0];
        if (full && !pop) overflow <= 1'b1;
      end
      if (status_wr && writedata[STAT_OVERFLOW]) overflow <= 1'b0;
      if (ctrl_wr) begin
        enable <= writedata[CTRL_ENABLE];
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (thresh_wr) threshold <= writedata[LVL_W-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[DATA_WIDTH-1:0] = last_wr;
      ADDR_STATUS: begin
        readdata[STAT_EMPTY]                  = empty;
        readdata[STAT_FULL]                   = full;
        readdata[STAT_OVERFLOW]               = overflow;
        readdata[STAT_IRQ_PEND]               = irq_pending;
        readdata[STAT_LEVEL_LSB +: LVL_W]     = level;
      end
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE] = enable;
        readdata[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_THRESH: readdata[LVL_W-1:0] = threshold;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios2_subsystem_pio_fifo_out.sv
// Randomized scoreboard bench for the FIFO-backed output PIO against a queue-based model.
module tb_nios2_subsystem_pio_fifo_out;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          irq;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]    m_q[$];
  logic [DW-1:0]    sb_q[$];
  logic             m_enable = 1'b1;
  logic             m_irq_en = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_irq = 1'b0;
  logic [LVL_W-1:0] m_thr = '0;
  logic [DW-1:0]    m_last = '0;
  bit               model_ok = 0;
  logic [DW-1:0]    mon_exp;

  nios2_subsystem_pio_fifo_out #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [1:0] a);
    int lvl;
    logic [31:0] r;
    lvl = m_q.size();
    r = '0;
    case (a)
      2'd0: r = m_last;
      2'd1: begin
        r[0] = (lvl == 0);
        r[1] = (lvl == DEPTH);
        r[2] = m_ovf;
        r[3] = (lvl <= int'(m_thr));
        r[8 +: LVL_W] = LVL_W'(lvl);
      end
      2'd2: begin
        r[0] = m_enable;
        r[2] = m_irq_en;
      end
      default: r[LVL_W-1:0] = m_thr;
    endcase
    return r;
  endfunction

  // One bus/stream cycle: drive, check visible state, then advance the model.
  task automatic applyStimulus(input logic rst, input logic cs, input logic wn,
                               input logic [1:0] a, input logic [31:0] wd, input logic rdy);
    bit wr;
    bit pop;
    bit irq_next;
    int lvl;
    @(posedge clk);
    #1;
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd; out_ready = rdy;
    #1;
    if (model_ok) begin
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, (m_enable && m_q.size() > 0)});
      if (m_q.size() == 0) checkOutput("out_data_empty", out_data, '0);
      checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
      if (cs && wn) begin
        case (a)
          2'd0:    checkOutput("read_data", readdata, expRead(a));
          2'd1:    checkOutput("read_status", readdata, expRead(a));
          2'd2:    checkOutput("read_ctrl", readdata, expRead(a));
          default: checkOutput("read_thresh", readdata, expRead(a));
        endcase
      end
    end
    if (rst) begin
      m_q.delete();
      m_enable = 1'b1; m_irq_en = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
      m_thr = '0; m_last = '0;
      model_ok = 1;
    end else begin
      lvl = m_q.size();
      wr = cs && !wn;
      pop = m_enable && lvl > 0 && rdy;
      irq_next = m_irq_en && (lvl <= int'(m_thr));
      if (pop) sb_q.push_back(m_q[0]);
      if (wr && a == 2'd2 && wd[1]) m_q.delete();
      else begin
        if (pop) m_q.delete(0);
        if (wr && a == 2'd0) begin
          if (lvl < DEPTH || pop) m_q.push_back(wd[DW-1:0]);
          else m_ovf = 1'b1;
        end
      end
      if (wr && a == 2'd0) m_last = wd[DW-1:0];
      if (wr && a == 2'd1 && wd[2]) m_ovf = 1'b0;
      if (wr && a == 2'd2) begin m_enable = wd[0]; m_irq_en = wd[2]; end
      if (wr && a == 2'd3) m_thr = wd[LVL_W-1:0];
      m_irq = irq_next;
    end
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d, input logic rdy);
    applyStimulus(1'b0, 1'b1, 1'b0, a, d, rdy);
  endtask

  task automatic busRead(input logic [1:0] a, input logic rdy);
    applyStimulus(1'b0, 1'b1, 1'b1, a, 32'h0, rdy);
  endtask

  task automatic idle(input logic rdy, input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, rdy);
  endtask

  task automatic doReset(input logic rdy);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, rdy);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) busWrite(2'd0, 32'(base + i), 1'b0);
  endtask

  // Monitor: every stream handshake must match the next predicted output.
  always @(negedge clk) begin
    if (model_ok && !reset) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pop: got data 0x%0h, expected no handshake at %0t", out_data, $time);
        end else begin
          mon_exp = sb_q.pop_front();
          checkOutput("stream_data", out_data, mon_exp);
        end
      end else if (sb_q.size() > 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL missing_pop: got no handshake, expected data 0x%0h at %0t", sb_q[0], $time);
        sb_q.delete();
      end
    end
  end

  initial begin
    int r;
    int bias;
    logic rdy;
    logic [31:0] wd;

    doReset(1'b0);
    busRead(2'd1, 1'b0);
    busRead(2'd2, 1'b0);
    busRead(2'd3, 1'b0);
    busRead(2'd0, 1'b0);

    busWrite(2'd0, 32'hA5, 1'b0);
    busRead(2'd1, 1'b0);
    busRead(2'd0, 1'b0);

    doReset(1'b0);
    fill(16, 0);
    busWrite(2'd0, 32'h99, 1'b0);
    busRead(2'd1, 1'b0);
    idle(1'b1, 17);
    busRead(2'd1, 1'b0);
    busWrite(2'd1, 32'h4, 1'b0);
    busRead(2'd1, 1'b0);

    fill(16, 32'h100);
    busWrite(2'd0, 32'h55, 1'b1);
    busRead(2'd1, 1'b0);
    idle(1'b1, 18);

    fill(8, 32'h200);
    busWrite(2'd2, 32'h3, 1'b1);
    busRead(2'd1, 1'b1);
    busRead(2'd2, 1'b1);

    busWrite(2'd2, 32'h0, 1'b0);
    fill(3, 32'h300);
    idle(1'b1, 3);
    busRead(2'd1, 1'b1);
    busWrite(2'd2, 32'h1, 1'b1);
    idle(1'b1, 4);
    busRead(2'd1, 1'b0);

    doReset(1'b0);
    busWrite(2'd3, 32'h2, 1'b0);
    busWrite(2'd2, 32'h5, 1'b0);
    fill(5, 32'h400);
    idle(1'b1, 7);
    fill(5, 32'h500);
    idle(1'b1, 2);
    doReset(1'b1);
    idle(1'b0, 2);
    busRead(2'd1, 1'b0);

    for (int blk = 0; blk < 6; blk++) begin
      bias = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      repeat (500) begin
        r = $urandom_range(0, 99);
        rdy = ($urandom_range(0, 99) < bias);
        if (r < 40) busWrite(2'd0, $urandom, rdy);
        else if (r < 52) busRead(2'($urandom_range(0, 3)), rdy);
        else if (r < 55) busWrite(2'd1, $urandom, rdy);
        else if (r < 59) begin
          wd = '0;
          wd[0] = ($urandom_range(0, 3) != 0);
          wd[1] = ($urandom_range(0, 7) == 0);
          wd[2] = $urandom_range(0, 1);
          busWrite(2'd2, wd, rdy);
        end
        else if (r < 62) busWrite(2'd3, $urandom, rdy);
        else if (r == 99 && $urandom_range(0, 9) == 0) doReset(rdy);
        else idle(rdy, 1);
      end
    end

    idle(1'b0, 1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
